// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Initiator side of the instruction-memory read port. Owns the fetch PC,
//   presents it as the byte address, and captures the big-endian word that
//   memory returns combinationally in the same cycle. Fetched {pc, instr}
//   pairs are queued in a small prefetch FIFO and handed to decode over a
//   valid/ready handshake. Supports branch redirect (flush + new PC) and a
//   level-sensitive halt request.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous, active-high reset
//   imem_addr      out  32  byte address to instruction memory (= fetch PC)
//   imem_instr     in   32  word at imem_addr, valid in the same cycle
//   redirect_valid in   1   branch/jump taken: flush and restart at redirect_pc
//   redirect_pc    in   32  new fetch address, bits [1:0] ignored
//   halt_req       in   1   while high, no new fetches (FIFO still drains)
//   out_valid      out  1   FIFO head holds a valid instruction
//   out_ready      in   1   decode accepts the head this cycle
//   out_instr      out  32  instruction at FIFO head
//   out_pc         out  32  address of out_instr
//   halted         out  1   halt state reached and FIFO empty
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
);

    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_after_pop;
    logic [31:0]   ent_pc_q    [FIFO_DEPTH];
    logic [31:0]   ent_pc_d    [FIFO_DEPTH];
    logic [31:0]   ent_instr_q [FIFO_DEPTH];
    logic [31:0]   ent_instr_d [FIFO_DEPTH];
    logic          push;
    logic          pop;

    // The low two redirect bits are deliberately discarded (word alignment).
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        count_d         = count_q;
        ent_pc_d        = ent_pc_q;
        ent_instr_d     = ent_instr_q;

        pop  = (count_q != '0) & out_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push = (state_q == ST_RUN) & ~halt_req & ~redirect_valid
             & ((count_q < DEPTH_C) | pop);
        count_after_pop = count_q - CW'(pop);

        unique case (state_q)
            ST_RUN:  if (halt_req)  state_d = ST_HALT;
            ST_HALT: if (!halt_req) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (redirect_valid) begin
            // Flush only clears the count; entry 0 keeps the last head so
            // out_pc/out_instr hold their value while out_valid is low.
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop) begin
                // Shift only occupied slots so a drained FIFO leaves the
                // popped word visible in entry 0.
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    if (CW'(i + 1) < count_q) begin
                        ent_pc_d[i]    = ent_pc_q[i + 1];
                        ent_instr_d[i] = ent_instr_q[i + 1];
                    end
                end
            end
            if (push) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (CW'(i) == count_after_pop) begin
                        ent_pc_d[i]    = fetch_pc_q;
                        ent_instr_d[i] = imem_instr;
                    end
                end
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            count_d = count_after_pop + CW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_pc_q[i]    <= '0;
                ent_instr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            count_q     <= count_d;
            ent_pc_q    <= ent_pc_d;
            ent_instr_q <= ent_instr_d;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = ent_pc_q[0];
    assign out_instr = ent_instr_q[0];
    assign halted    = (state_q == ST_HALT) && (count_q == '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_ready;
    logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid, halted;

    logic [31:0] imem_addr2, imem_instr2, out_instr2, out_pc2;
    logic        out_valid2, halted2;

    int total = 0;
    int bad   = 0;

    // Instruction memory contents: an address-dependent word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + {a[15:0], a[31:16]};
    endfunction

    assign imem_instr  = mem_word(imem_addr);
    assign imem_instr2 = mem_word(imem_addr2);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .halt_req(1'b0), .out_valid(out_valid2), .out_ready(1'b1),
        .out_instr(out_instr2), .out_pc(out_pc2), .halted(halted2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue of fetched words ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc         = 32'h0;
    logic [31:0] m_show_pc    = 32'h0;
    logic [31:0] m_show_instr = 32'h0;
    bit          m_halt       = 1'b0;

    always @(posedge clk) begin : model
        bit pop, push;
        if (rst) begin
            mq.delete();
            m_pc         = 32'h0;
            m_show_pc    = 32'h0;
            m_show_instr = 32'h0;
            m_halt       = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            push = 1'b0;
            if (redirect_valid) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                push = !m_halt && !halt_req && ((mq.size() < DEPTH) || pop);
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back('{m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
            // Halt mode simply follows the level of halt_req one edge later.
            m_halt = halt_req;
            if (mq.size() > 0) begin
                m_show_pc    = mq[0].pc;
                m_show_instr = mq[0].instr;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        chk1("m_valid", out_valid, mq.size() > 0);
        chk("m_addr", imem_addr, m_pc);
        chk("m_pc", out_pc, m_show_pc);
        chk("m_instr", out_instr, m_show_instr);
        chk1("m_halted", halted, m_halt && (mq.size() == 0));
    end

    logic [31:0] wrap_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    initial begin
        int n;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        out_ready      = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk1("rst_halted", halted, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
        chk1("rst_halted2", halted2, 1'b0);

        // Streaming from reset; wrap-around instance in parallel
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("t1_valid", out_valid, 1'b1);
            chk("t1_pc", out_pc, 32'(4 * i));
            chk("t1_instr", out_instr, mem_word(32'(4 * i)));
            chk1("t4_valid", out_valid2, 1'b1);
            chk("t4_pc", out_pc2, wrap_exp[i]);
            chk("t4_instr", out_instr2, mem_word(wrap_exp[i]));
        end

        // Back-pressure after reset: FIFO saturates, then drains in order
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("t2_addr", imem_addr, 32'h8);
        chk("t2_head", out_pc, 32'h0);
        chk1("t2_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_seq", out_pc, 32'(4 * i));
        end

        // Redirect while full
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        @(negedge clk);
        chk1("t3_valid", out_valid, 1'b0);
        chk("t3_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk1("t3_valid2", out_valid, 1'b1);
        chk("t3_pc", out_pc, 32'h40);
        chk("t3_instr", out_instr, mem_word(32'h40));

        // Halt with two entries queued
        out_ready = 1'b0;
        @(negedge clk);
        halt_req  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_pc", out_pc, 32'h44);
        @(negedge clk);
        chk1("t5_valid", out_valid, 1'b0);
        chk1("t5_halted", halted, 1'b1);
        chk("t5_addr", imem_addr, 32'h48);
        // Redirect while halted updates the PC but stays halted
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t5_redir_addr", imem_addr, 32'h200);
        chk1("t5_redir_halted", halted, 1'b1);
        halt_req = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk1("t5_resume_in_time", n < 10, 1'b1);
        chk("t5_resume_pc", out_pc, 32'h200);

        // Reset pulse with redirect and halt also asserted
        chk1("t6_pre_valid", out_valid, 1'b1);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        halt_req       = 1'b1;
        @(negedge clk);
        chk1("t6_valid", out_valid, 1'b0);
        chk("t6_addr", imem_addr, 32'h0);
        chk1("t6_halted", halted, 1'b0);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            out_ready      = (i % 3) != 0;
            halt_req       = (i % 17) >= 12;
            redirect_valid = (i % 13) == 7;
            redirect_pc    = 32'h1000 + 32'(i * 8) + 32'(i % 4);
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        out_ready      = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
